// File: rtl/column_gather.sv
// Column gather: fetches descriptor words, keeps the column's byte window and
// packs the kept bytes contiguously into 16-byte output lines, flushing at frame end.
module column_gather #(
  parameter int ADDR      = 32,
  parameter int MAX_WORDS = 5
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_desc_valid,
  output logic            o_desc_ready,
  input  logic [ADDR-1:0] i_rd_addr,
  input  logic [4:0]      i_rd_size,
  input  logic [3:0]      i_rd_start,
  input  logic [15:0]     i_width,
  input  logic            i_last,
  output logic            o_mem_req,
  output logic [ADDR-1:0] o_mem_addr,
  input  logic            i_mem_gnt,
  input  logic            i_mem_rvalid,
  output logic            o_mem_rready,
  input  logic [127:0]    i_mem_rdata,
  output logic            o_line_valid,
  output logic [127:0]    o_line_data,
  output logic [15:0]     o_line_strb,
  output logic            o_line_last,
  input  logic            i_line_ready,
  output logic            o_err
);

  localparam int CW = $clog2(MAX_WORDS + 1);

  typedef enum logic [1:0] {IDLE, BUSY, FLUSH} state_t;

  state_t          state, state_nxt;
  logic [ADDR-1:0] mem_addr;
  logic [3:0]      start_q;
  logic [15:0]     width_q;
  logic            last_q;
  logic [CW-1:0]   req_left, beat_left, beat_idx;
  logic [255:0]    acc, acc_s, acc_nxt;
  logic [5:0]      fill, fill_s, fill_nxt;
  logic            err_q;

  logic            desc_acc, gnt_acc, beat_use, out_free;
  logic            emit_full, emit_part, done, frame_end, full_last;
  logic [13:0]     calc_size;
  logic [17:0]     base, w_lo, w_hi, lo, hi;
  logic [4:0]      nkeep;
  logic [127:0]    beat_sh, keep_mask, part_mask;
  logic [15:0]     part_strb;

  assign o_desc_ready = (state == IDLE) && !i_rst;
  assign o_mem_req    = (state == BUSY) && (req_left != '0);
  assign o_mem_addr   = mem_addr;
  assign o_mem_rready = (state == BUSY) && (fill < 6'd16);
  assign o_err        = err_q;

  assign desc_acc  = i_desc_valid && o_desc_ready;
  assign gnt_acc   = o_mem_req && i_mem_gnt;
  assign beat_use  = o_mem_rready && i_mem_rvalid && (beat_left != '0);
  assign calc_size = 14'((18'(i_rd_start) + 18'(i_width) + 18'd15) >> 4);

  assign out_free  = !o_line_valid || i_line_ready;
  assign done      = (state == BUSY) && (req_left == '0) && (beat_left == '0);
  assign frame_end = last_q && (done || (state == FLUSH));
  assign emit_full = (fill >= 6'd16) && out_free;
  assign emit_part = (state == FLUSH) && (fill != '0) && (fill < 6'd16) && out_free;
  // A full line closes the frame only when it takes every remaining byte.
  assign full_last = frame_end && (fill == 6'd16);

  // Kept bytes of a beat form one contiguous slice [lo, hi) of that beat.
  always_comb begin
    base = 18'({beat_idx, 4'b0000});
    w_lo = 18'(start_q);
    w_hi = 18'(start_q) + 18'(width_q);
    lo   = (w_lo > base) ? w_lo - base : '0;
    hi   = (w_hi > base) ? w_hi - base : '0;
    if (lo > 18'd16) lo = 18'd16;
    if (hi > 18'd16) hi = 18'd16;
    nkeep     = (hi > lo) ? 5'(hi - lo) : '0;
    beat_sh   = i_mem_rdata >> {lo[4:0], 3'b000};
    keep_mask = ~({128{1'b1}} << {nkeep, 3'b000});
  end

  always_comb begin
    part_strb = (16'd1 << fill[3:0]) - 16'd1;
    part_mask = '0;
    for (int unsigned i = 0; i < 16; i++) part_mask[8*i +: 8] = {8{part_strb[i]}};
  end

  // Drain first, then append the beat at the post-drain fill point.
  always_comb begin
    acc_s  = emit_full ? (acc >> 128) : acc;
    fill_s = emit_full ? (fill - 6'd16) : (emit_part ? '0 : fill);
    acc_nxt  = acc_s;
    fill_nxt = fill_s;
    if (beat_use) begin
      acc_nxt  = (acc_s & ~({256{1'b1}} << {fill_s, 3'b000}))
               | ({128'b0, beat_sh & keep_mask} << {fill_s, 3'b000});
      fill_nxt = fill_s + {1'b0, nkeep};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (desc_acc) state_nxt = BUSY;
      BUSY:    if (done) state_nxt = last_q ? FLUSH : IDLE;
      FLUSH:   if (fill == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      mem_addr     <= '0;
      start_q      <= '0;
      width_q      <= '0;
      last_q       <= 1'b0;
      req_left     <= '0;
      beat_left    <= '0;
      beat_idx     <= '0;
      acc          <= '0;
      fill         <= '0;
      err_q        <= 1'b0;
      o_line_valid <= 1'b0;
      o_line_data  <= '0;
      o_line_strb  <= '0;
      o_line_last  <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      fill  <= fill_nxt;
      if (desc_acc) begin
        mem_addr  <= i_rd_addr;
        start_q   <= i_rd_start;
        width_q   <= i_width;
        last_q    <= i_last;
        req_left  <= calc_size[CW-1:0];
        beat_left <= calc_size[CW-1:0];
        beat_idx  <= '0;
        if (14'(i_rd_size) != calc_size) err_q <= 1'b1;
      end else begin
        if (gnt_acc) begin
          req_left <= req_left - CW'(1);
          mem_addr <= mem_addr + ADDR'(1);
        end
        if (beat_use) begin
          beat_left <= beat_left - CW'(1);
          beat_idx  <= beat_idx + CW'(1);
        end
      end
      if (emit_full) begin
        o_line_valid <= 1'b1;
        o_line_data  <= acc[127:0];
        o_line_strb  <= 16'hFFFF;
        o_line_last  <= full_last;
      end else if (emit_part) begin
        o_line_valid <= 1'b1;
        o_line_data  <= acc[127:0] & part_mask;
        o_line_strb  <= part_strb;
        o_line_last  <= 1'b1;
      end else if (i_line_ready) begin
        o_line_valid <= 1'b0;
        o_line_data  <= '0;
        o_line_strb  <= '0;
        o_line_last  <= 1'b0;
      end
    end
  end

endmodule
